// File: rtl/tile_update_scheduler.sv
// tile_update_scheduler: sole write controller for the background tile map.
// Requesters post tile writes. A single grant per cycle moves one post into a
// small FIFO. On vblank_start the entries queued at that moment are written to
// the map, one per cycle, so the map only changes during vertical blanking.
// Optional build macro TILE_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// replaces round-robin arbitration and removes the round-robin pointer.
module tile_update_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MAP_ROWS   = 12,
  parameter int MAP_COLS   = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vblank_start,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*4-1:0] req_row,
  input  logic [NUM_REQ*5-1:0] req_col,
  input  logic [NUM_REQ*8-1:0] req_tile,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 map_we,
  output logic [3:0]           map_row,
  output logic [4:0]           map_col,
  output logic [7:0]           map_tile,
  output logic                 frame_done,
  output logic                 err_range,
  output logic                 err_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifndef TILE_ARB_FIXED_PRIO_EN
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic [3:0] row;
    logic [4:0] col;
    logic [7:0] tile;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] left_q, left_d;
  logic [1:0]    state_q, state_d;
  logic          map_we_q;
  entry_t        out_q;
  logic          err_range_q, err_overflow_q;
`ifndef TILE_ARB_FIXED_PRIO_EN
  logic [RW-1:0] rr_ptr_q, rr_nxt;
`endif

  logic   pop, push, accept, in_range, full_block, found;
  entry_t sel_entry;

  // Drain FSM: snapshot the queue depth on vblank_start and pop exactly that many.
  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vblank_start) begin
          if (count_q == '0) begin
            state_d = ST_DONE;
          end else begin
            pop     = 1'b1;
            left_d  = count_q - 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (left_q != '0) begin
          pop    = 1'b1;
          left_d = left_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter: grant at most one valid requester when the FIFO has room after any pop.
  always_comb begin
    req_ready  = '0;
    found      = 1'b0;
    sel_entry  = '0;
    full_block = (count_q == CW'(FIFO_DEPTH)) && !pop;
`ifdef TILE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found        = 1'b1;
        req_ready[i] = !reset && !full_block;
        sel_entry    = '{req_row[4*i +: 4], req_col[5*i +: 5], req_tile[8*i +: 8]};
      end
    end
`else
    rr_nxt = '0;
    // First pass covers indices at or after the pointer, second pass wraps around.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        found        = 1'b1;
        req_ready[i] = !reset && !full_block;
        sel_entry    = '{req_row[4*i +: 4], req_col[5*i +: 5], req_tile[8*i +: 8]};
        rr_nxt       = (i == NUM_REQ - 1) ? '0 : RW'(i + 1);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found        = 1'b1;
        req_ready[i] = !reset && !full_block;
        sel_entry    = '{req_row[4*i +: 4], req_col[5*i +: 5], req_tile[8*i +: 8]};
        rr_nxt       = (i == NUM_REQ - 1) ? '0 : RW'(i + 1);
      end
    end
`endif
    accept   = |req_ready;
    in_range = ({1'b0, sel_entry.row} < 5'(MAP_ROWS)) &&
               ({1'b0, sel_entry.col} < 6'(MAP_COLS));
    push     = accept && in_range;
  end

  // Control state, FIFO pointers, map write port and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      left_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      map_we_q       <= 1'b0;
      out_q          <= '0;
      err_range_q    <= 1'b0;
      err_overflow_q <= 1'b0;
`ifndef TILE_ARB_FIXED_PRIO_EN
      rr_ptr_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      map_we_q <= pop;
      if (pop) out_q <= mem_q[rd_ptr_q];
      if (accept && !in_range)        err_range_q    <= 1'b1;
      if ((|req_valid) && full_block) err_overflow_q <= 1'b1;
`ifndef TILE_ARB_FIXED_PRIO_EN
      if (accept) rr_ptr_q <= rr_nxt;
`endif
    end
  end

  // FIFO storage; only in-range accepted posts are written.
  // NOTE: the storage array has no reset; the pointers and count define which
  // slots are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sel_entry;
  end

  assign map_we       = map_we_q;
  assign map_row      = out_q.row;
  assign map_col      = out_q.col;
  assign map_tile     = out_q.tile;
  assign frame_done   = (state_q == ST_DONE);
  assign err_range    = err_range_q;
  assign err_overflow = err_overflow_q;

endmodule
